// File: rtl/lcd_init_sequencer.sv
// Power-on init sequencer for an HD44780-style LCD in 8-bit mode: waits out the
// power-up delay, then issues the fixed command list with timed gaps between commands.
module lcd_init_sequencer #(
    parameter logic [5:0] POWERUP_MS = 6'd20,
    parameter logic [7:0] FUNC_SET   = 8'h38,
    parameter logic [7:0] DISP_CTRL  = 8'h0C,
    parameter logic [7:0] ENTRY_MODE = 8'h06,
    parameter logic [5:0] CLEAR_MS   = 6'd2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       start,
    input  logic       timer_tick,
    output logic       timer_en,
    output logic       timer_rst_n,
    output logic       cmd_valid,
    output logic [7:0] cmd_data,
    output logic       cmd_rs,
    input  logic       cmd_ready,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, WAIT, SEND, DONE} state_t;

    state_t     state, state_n;
    // One extra step bit so "all eight commands sent" (step 8) is distinct from step 0
    logic [3:0] step, step_n;
    logic [5:0] ms_cnt, ms_n;
    logic [7:0] data_n;
    logic       restart, restart_n;

    function automatic logic [7:0] rom_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: rom_byte = 8'h30;
            3'd3:             rom_byte = FUNC_SET;
            3'd4:             rom_byte = 8'h08;
            3'd5:             rom_byte = 8'h01;
            3'd6:             rom_byte = ENTRY_MODE;
            default:          rom_byte = DISP_CTRL;
        endcase
    endfunction

    function automatic logic [5:0] rom_delay(input logic [2:0] idx);
        case (idx)
            3'd0:    rom_delay = 6'd5;
            3'd5:    rom_delay = CLEAR_MS;
            default: rom_delay = 6'd1;
        endcase
    endfunction

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state    <= IDLE;
            step     <= 4'd0;
            ms_cnt   <= 6'd0;
            cmd_data <= 8'h00;
            restart  <= 1'b0;
        end else begin
            state    <= state_n;
            step     <= step_n;
            ms_cnt   <= ms_n;
            cmd_data <= data_n;
            restart  <= restart_n;
        end
    end

    // The restart cycle clears the timer, so any tick seen then is stale and ignored
    always_comb begin
        state_n   = state;
        step_n    = step;
        ms_n      = ms_cnt;
        data_n    = cmd_data;
        restart_n = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n   = WAIT;
                    step_n    = 4'd0;
                    ms_n      = POWERUP_MS;
                    restart_n = 1'b1;
                end
            end
            WAIT: begin
                if (timer_tick && !restart) begin
                    if (ms_cnt == 6'd1) begin
                        if (step == 4'd8) begin
                            state_n = DONE;
                        end else begin
                            state_n = SEND;
                            data_n  = rom_byte(step[2:0]);
                        end
                    end else begin
                        ms_n = ms_cnt - 6'd1;
                    end
                end
            end
            SEND: begin
                if (cmd_ready) begin
                    state_n   = WAIT;
                    step_n    = step + 4'd1;
                    ms_n      = rom_delay(step[2:0]);
                    restart_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign timer_rst_n = Rst & ~restart;
    assign timer_en    = (state == WAIT) & ~restart;
    assign cmd_valid   = (state == SEND);
    assign cmd_rs      = 1'b0;
    assign busy        = (state == WAIT) || (state == SEND);
    assign done        = (state == DONE);

endmodule
